vic_regfile_param: RTL and testbench

//  Parametrised VIC configuration register file; successor to the fixed 32x4 bank.

---
 rtl/vic_regs_pkg.sv | 26 ++
 rtl/vic_reg_sweep_ctrl.sv | 94 +++++++++
 rtl/vic_regfile_param.sv | 170 +++++++++++++++++
 tb/tb_vic_regfile_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vic_regs_pkg.sv
// ---------------------------------------------------------------------------
// vic_regs_pkg
//   Shared definitions for the VIC configuration register file:
//   - write-mode encodings applied by the register ALU
//   - clear-sweep FSM state encoding
//   - register index range check helper
// ---------------------------------------------------------------------------
package vic_regs_pkg;

    localparam logic [1:0] WMODE_WRITE  = 2'b00;  // reg = wdata
    localparam logic [1:0] WMODE_SET    = 2'b01;  // reg = reg | wdata
    localparam logic [1:0] WMODE_CLEAR  = 2'b10;  // reg = reg & ~wdata
    localparam logic [1:0] WMODE_TOGGLE = 2'b11;  // reg = reg ^ wdata

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // True when addr selects an implemented register.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] num_regs);
        return (addr < num_regs);
    endfunction

endpackage

// File: rtl/vic_reg_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// vic_reg_sweep_ctrl
//   Clear-all sweep controller. On i_start in IDLE it walks an index from 0 to
//   NUM_REGS-1, one register per cycle, then returns to IDLE, so o_busy is
//   high for exactly NUM_REGS cycles.
// Ports
//   i_clk      clock
//   i_rst      asynchronous active-high reset (aborts a running sweep)
//   i_start    request a sweep (ignored while sweeping)
//   o_busy     sweep in progress
//   o_clr_idx  register index cleared at the coming edge
//   o_clr_en   clear strobe for o_clr_idx
// ---------------------------------------------------------------------------
module vic_reg_sweep_ctrl
    import vic_regs_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_clr_idx,
    output logic              o_clr_en
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    sweep_state_e      state_r;
    sweep_state_e      state_s;
    logic [ADDR_W-1:0] cnt_r;

    // State register and sweep index counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= IDX_ZERO;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_SWEEP) && (cnt_r != LAST_IDX)) begin
                cnt_r <= cnt_r + IDX_ONE;
            end else begin
                cnt_r <= IDX_ZERO;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_SWEEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        o_busy    = 1'b0;
        o_clr_en  = 1'b0;
        o_clr_idx = cnt_r;
        case (state_r)
            ST_IDLE: begin
                o_busy   = 1'b0;
                o_clr_en = 1'b0;
            end
            ST_SWEEP: begin
                o_busy   = 1'b1;
                o_clr_en = 1'b1;
            end
            default: begin
                o_busy   = 1'b0;
                o_clr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vic_regfile_param.sv
// ---------------------------------------------------------------------------
// vic_regfile_param
//   Parametrised VIC configuration register file. NUM_REGS registers of
//   DATA_W bits are packed into o_buffer (reg k at [k*DATA_W +: DATA_W]).
//   Supports WRITE/SET/CLEAR/TOGGLE writes, registered reads with a valid
//   pulse, an error pulse for out-of-range or rejected accesses, and a
//   sequential clear-all sweep.
// Configuration
//   VIC_REG_SHADOW_EN  when defined, accesses target a shadow array and
//                      i_commit copies shadow into the live array.
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_regaddr          register index for read/write
//   i_wdata, i_we      write operand and strobe
//   i_wmode            write mode (see vic_regs_pkg)
//   i_re               read strobe
//   o_rdata, o_rvalid  read data and its one-cycle valid
//   o_err              one-cycle error pulse
//   i_clear_all        start clear sweep
//   o_busy             sweep in progress
//   i_commit           shadow->live copy (VIC_REG_SHADOW_EN only)
//   o_buffer           live registers, flat
// ---------------------------------------------------------------------------
module vic_regfile_param
    import vic_regs_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [ADDR_W-1:0]          i_regaddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_we,
    input  logic [1:0]                 i_wmode,
    input  logic                       i_re,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_rvalid,
    output logic                       o_err,
    input  logic                       i_clear_all,
    output logic                       o_busy,
`ifdef VIC_REG_SHADOW_EN
    input  logic                       i_commit,
`endif
    output logic [NUM_REGS*DATA_W-1:0] o_buffer
);

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [NUM_REGS-1:0][DATA_W-1:0] live_r;
    logic [NUM_REGS-1:0][DATA_W-1:0] tgt_s;     // array seen by CPU accesses
    logic [ADDR_W-1:0]               clr_idx_s;
    logic                            clr_en_s;
    logic                            busy_s;
    logic                            in_range_s;
    logic                            acc_ok_s;
    logic                            wr_en_s;
    logic                            rd_en_s;
    logic                            err_s;
    logic [DATA_W-1:0]               cur_s;
    logic [DATA_W-1:0]               wr_val_s;

    vic_reg_sweep_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sweep (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_clear_all),
        .o_busy    (busy_s),
        .o_clr_idx (clr_idx_s),
        .o_clr_en  (clr_en_s)
    );

`ifdef VIC_REG_SHADOW_EN
    logic [NUM_REGS-1:0][DATA_W-1:0] shadow_r;
    logic                            commit_en_s;

    assign tgt_s = shadow_r;
    // A commit alongside a clear request loses to the sweep.
    assign commit_en_s = i_commit && !busy_s && !i_clear_all;
`else
    assign tgt_s = live_r;
`endif

    // Access qualification: a sweep (running or starting now) rejects accesses.
    always_comb begin
        in_range_s = addr_in_range(32'(i_regaddr), 32'(NUM_REGS));
        acc_ok_s   = !busy_s && !i_clear_all;
        wr_en_s    = i_we && acc_ok_s && in_range_s;
        rd_en_s    = i_re && acc_ok_s;
        if (i_we || i_re) begin
            err_s = !acc_ok_s || !in_range_s;
        end else begin
            err_s = 1'b0;
        end
    end

    // Write-mode ALU on the currently addressed register.
    always_comb begin
        if (in_range_s) begin
            cur_s = tgt_s[i_regaddr];
        end else begin
            cur_s = DATA_ZERO;
        end
        case (i_wmode)
            WMODE_WRITE:  wr_val_s = i_wdata;
            WMODE_SET:    wr_val_s = cur_s | i_wdata;
            WMODE_CLEAR:  wr_val_s = cur_s & ~i_wdata;
            WMODE_TOGGLE: wr_val_s = cur_s ^ i_wdata;
            default:      wr_val_s = i_wdata;
        endcase
    end

    // Live register array: sweep clear, then direct write or commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            live_r <= '0;
        end else if (clr_en_s) begin
            live_r[clr_idx_s] <= DATA_ZERO;
`ifdef VIC_REG_SHADOW_EN
        end else if (commit_en_s) begin
            live_r <= shadow_r;   // pre-write shadow image
`else
        end else if (wr_en_s) begin
            live_r[i_regaddr] <= wr_val_s;
`endif
        end else begin
            live_r <= live_r;
        end
    end

`ifdef VIC_REG_SHADOW_EN
    // Shadow register array: sweep clear, then CPU write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_r <= '0;
        end else if (clr_en_s) begin
            shadow_r[clr_idx_s] <= DATA_ZERO;
        end else if (wr_en_s) begin
            shadow_r[i_regaddr] <= wr_val_s;
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    // Read data, read valid and error pulse; rdata holds between reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata  <= DATA_ZERO;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_err <= err_s;
            if (rd_en_s) begin
                o_rvalid <= 1'b1;
                o_rdata  <= cur_s;   // zero when out of range
            end else begin
                o_rvalid <= 1'b0;
                o_rdata  <= o_rdata;
            end
        end
    end

    assign o_buffer = live_r;
    assign o_busy   = busy_s;

endmodule

// File: tb/tb_vic_regfile_param.sv
module tb_vic_regfile_param;
    import vic_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  regaddr;
    logic [3:0]  wdata;
    logic        we;
    logic [1:0]  wmode;
    logic        re;
    logic        clear_all;
    logic        commit;

    // DUT A: 32 registers
    logic [3:0]   rdata_a;
    logic         rvalid_a, err_a, busy_a;
    logic [127:0] buf_a;
    // DUT B: 20 registers (out-of-range checks)
    logic [3:0]   rdata_b;
    logic         rvalid_b, err_b, busy_b;
    logic [79:0]  buf_b;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    vic_regfile_param #(.NUM_REGS(32), .DATA_W(4), .ADDR_W(5)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_regaddr(regaddr), .i_wdata(wdata),
        .i_we(we), .i_wmode(wmode), .i_re(re), .o_rdata(rdata_a),
        .o_rvalid(rvalid_a), .o_err(err_a), .i_clear_all(clear_all),
        .o_busy(busy_a),
`ifdef VIC_REG_SHADOW_EN
        .i_commit(commit),
`endif
        .o_buffer(buf_a)
    );

    vic_regfile_param #(.NUM_REGS(20), .DATA_W(4), .ADDR_W(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_regaddr(regaddr), .i_wdata(wdata),
        .i_we(we), .i_wmode(wmode), .i_re(re), .o_rdata(rdata_b),
        .o_rvalid(rvalid_b), .o_err(err_b), .i_clear_all(clear_all),
        .o_busy(busy_b),
`ifdef VIC_REG_SHADOW_EN
        .i_commit(commit),
`endif
        .o_buffer(buf_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d, input logic [1:0] m);
        regaddr = a; wdata = d; wmode = m; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a);
        regaddr = a; re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    // Expected DUT A buffer k cycles into a sweep of an all-0xF file.
    function automatic logic [127:0] sweep_exp(input int k);
        logic [127:0] v;
        v = 128'd0;
        for (int i = 0; i < 32; i++) begin
            v[i*4 +: 4] = (i >= k) ? 4'hF : 4'h0;
        end
        return v;
    endfunction

    initial begin
        logic [127:0] exp_b;
        rst = 1'b1; regaddr = 5'd0; wdata = 4'h0; we = 1'b0; wmode = WMODE_WRITE;
        re = 1'b0; clear_all = 1'b0; commit = 1'b0;
        tick(); tick();
        // Reset state
        chk("rst_buf",    buf_a,             128'd0);
        chk("rst_rdata",  128'(rdata_a),     128'd0);
        chk("rst_rvalid", 128'(rvalid_a),    128'd0);
        chk("rst_err",    128'(err_a),       128'd0);
        chk("rst_busy",   128'(busy_a),      128'd0);
        rst = 1'b0;
        tick();

`ifndef VIC_REG_SHADOW_EN
        // 1: WRITE reg3 = 0xA, then read it back
        do_write(5'd3, 4'hA, WMODE_WRITE);
        chk("w3_buf", 128'(buf_a[15:12]), 128'(4'hA));
        do_read(5'd3);
        chk("r3_valid", 128'(rvalid_a), 128'd1);
        chk("r3_data",  128'(rdata_a),  128'(4'hA));
        tick();
        chk("r3_valid_drop", 128'(rvalid_a), 128'd0);
        chk("r3_data_hold",  128'(rdata_a),  128'(4'hA));

        // 2: write modes on reg5
        do_write(5'd5, 4'h6, WMODE_WRITE);
        chk("w5_write", 128'(buf_a[23:20]), 128'(4'h6));
        do_write(5'd5, 4'h9, WMODE_SET);
        chk("w5_set", 128'(buf_a[23:20]), 128'(4'hF));
        do_write(5'd5, 4'h3, WMODE_CLEAR);
        chk("w5_clear", 128'(buf_a[23:20]), 128'(4'hC));
        do_write(5'd5, 4'hF, WMODE_TOGGLE);
        chk("w5_toggle", 128'(buf_a[23:20]), 128'(4'h3));
        chk("nb_reg4", 128'(buf_a[19:16]), 128'(4'h0));
        chk("nb_reg6", 128'(buf_a[27:24]), 128'(4'h0));
        chk("nb_reg3", 128'(buf_a[15:12]), 128'(4'hA));

        // Same-cycle write+read of reg5 returns pre-write value
        regaddr = 5'd5; wdata = 4'h0; wmode = WMODE_WRITE; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("rw_rdata", 128'(rdata_a),      128'(4'h3));
        chk("rw_buf",   128'(buf_a[23:20]), 128'(4'h0));

        // 3: out-of-range on 20-register instance
        do_read(5'd31);
        chk("oor_rdata",  128'(rdata_b),  128'd0);
        chk("oor_rvalid", 128'(rvalid_b), 128'd1);
        chk("oor_err",    128'(err_b),    128'd1);
        chk("inr_err",    128'(err_a),    128'd0);
        exp_b = 128'd0;
        exp_b[15:12] = 4'hA;
        do_write(5'd31, 4'hF, WMODE_WRITE);
        chk("oor_w_err", 128'(err_b), 128'd1);
        chk("oor_w_buf", 128'(buf_b), exp_b);
        tick();
        chk("oor_err_drop", 128'(err_b), 128'd0);

        // 4: fill all, sweep, write mid-sweep
        for (int i = 0; i < 32; i++) do_write(5'(i), 4'hF, WMODE_WRITE);
        chk("fill_buf", buf_a, {128{1'b1}});
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("sw_busy_%0d", k), 128'(busy_a), 128'd1);
            chk($sformatf("sw_buf_%0d", k), buf_a, sweep_exp(k));
            if (k == 5) begin
                regaddr = 5'd20; wdata = 4'h0; wmode = WMODE_WRITE; we = 1'b1;
            end
            tick();
            if (k == 5) begin
                we = 1'b0;
                chk("sw_w_err",    128'(err_a),    128'd1);
                chk("sw_w_rvalid", 128'(rvalid_a), 128'd0);
                chk("sw_w_reg20",  128'(buf_a[83:80]), 128'(4'hF));
            end
        end
        chk("sw_done_busy", 128'(busy_a), 128'd0);
        chk("sw_done_buf",  buf_a,        128'd0);

        // 5: clear_all with read in IDLE -> sweep wins; then async reset mid-sweep
        do_write(5'd12, 4'h9, WMODE_WRITE);
        regaddr = 5'd12; re = 1'b1; clear_all = 1'b1;
        tick();
        re = 1'b0; clear_all = 1'b0;
        chk("cr_err",    128'(err_a),    128'd1);
        chk("cr_rvalid", 128'(rvalid_a), 128'd0);
        chk("cr_busy",   128'(busy_a),   128'd1);
        repeat (10) tick();
        chk("pre_rst_reg12", 128'(buf_a[51:48]), 128'(4'h9));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy_a), 128'd0);
        chk("arst_buf",  buf_a,        128'd0);
        tick();
        rst = 1'b0;
        tick();
`else
        // 6: shadow array, commit to live
        do_write(5'd2, 4'h7, WMODE_WRITE);
        chk("sh_live_unch", 128'(buf_a[11:8]), 128'(4'h0));
        do_read(5'd2);
        chk("sh_rdata",  128'(rdata_a),  128'(4'h7));
        chk("sh_rvalid", 128'(rvalid_a), 128'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("sh_commit", 128'(buf_a[11:8]), 128'(4'h7));
        // commit with same-cycle write copies the pre-write shadow
        regaddr = 5'd2; wdata = 4'h1; wmode = WMODE_WRITE; we = 1'b1; commit = 1'b1;
        tick();
        we = 1'b0; commit = 1'b0;
        chk("sh_commit_pre", 128'(buf_a[11:8]), 128'(4'h7));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("sh_commit_new", 128'(buf_a[11:8]), 128'(4'h1));
        // sweep clears both arrays
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        repeat (32) tick();
        chk("sh_sweep_live", buf_a, 128'd0);
        do_read(5'd2);
        chk("sh_sweep_shadow", 128'(rdata_a), 128'd0);
        chk("sh_idle_busy",    128'(busy_a),  128'd0);
        chk("sh_b_busy",       128'(busy_b),  128'd0);
        chk("sh_b_buf",        128'(buf_b),   128'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
